uart2sram_cmd_ctrl: RTL and testbench
=====================================

# uart2sram_cmd_ctrl

Command sequencer between the UART byte cores and the SRAM ports of the uart2sram bridge. It parses a byte-oriented command stream from the UART receiver into single SRAM write or read transactions. It returns one response byte per command to the UART transmitter through a valid/ready handshake. Partial frames are guarded by an inter-byte timeout, and overrun or protocol errors are flagged.

## Interface
Parameters:
- ADDR_WIDTH, 8, SRAM address width; legal range 1..8; address is taken from the low bits of the address byte.
- TIMEOUT_CYCLES, 1_000_000, idle cycles allowed between bytes of one frame; 0 disables the timeout.
- TIMEOUT_WIDTH, 32, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  sole clock; all logic rising-edge.
- rst_in  input  1  reset; **asynchronous, active-high**.
- rx_valid  input  1  single-cycle strobe: rx_data holds a received byte; no backpressure.
- rx_data  input  8  received byte.
- tx_valid  output  1  response byte available.
- tx_data  output  8  response byte; stable while tx_valid=1.
- tx_ready  input  1  transmitter accepts byte when tx_valid&&tx_ready.
- sram_wr_en  output  1  one-cycle write strobe.
- sram_wr_addr  output  ADDR_WIDTH  write address.
- sram_wr_data  output  8  write data.
- sram_rd_en  output  1  one-cycle read strobe.
- sram_rd_addr  output  ADDR_WIDTH  read address.
- sram_rd_data  input  8  read data, valid exactly 1 cycle after sram_rd_en.
- busy  output  1  high in every state except IDLE.
- err_timeout  output  1  one-cycle pulse: partial frame abandoned.
- err_overrun  output  1  one-cycle pulse: byte arrived while not accepting.

## Operation
- Frames: write = 0x57 'W', addr, data; read = 0x52 'R', addr. Responses: write → 0x4B 'K'; read → data byte; any other command byte → 0x3F '?'.
- States: IDLE, ADDR, WDATA, WRITE, READ, RWAIT, RESP.
- IDLE + rx byte: 'W'/'R' → ADDR (latch opcode); else latch tx byte 0x3F → RESP.
- ADDR + rx byte: latch addr = rx_data[ADDR_WIDTH-1:0]; opcode W → WDATA, R → READ.
- WDATA + rx byte: latch data → WRITE.
- WRITE: sram_wr_en=1 for this cycle only; load tx byte 0x4B → RESP.
- READ: sram_rd_en=1 for this cycle only → RWAIT.
- RWAIT: capture sram_rd_data into tx byte → RESP.
- RESP: tx_valid=1; on tx_ready → IDLE.
- Bytes accepted only in IDLE, ADDR, and WDATA. An rx_valid in WRITE, READ, RWAIT, or RESP is dropped and err_overrun pulses the next cycle. The state is unaffected.
- Timeout: the counter clears on entering ADDR/WDATA and on every accepted byte, and increments each cycle in ADDR/WDATA. When it reaches TIMEOUT_CYCLES-1 without rx_valid, the block → IDLE, err_timeout pulses the next cycle, and no SRAM access or response occurs. rx_valid on the expiry cycle wins: the byte is accepted and there is no timeout.
- sram_wr_addr/sram_rd_addr/sram_wr_data are driven from the latched registers and hold their values between transactions.
- Reset mid-frame or mid-response: everything returns to IDLE immediately; a pending response is discarded, with no strobe or tx_valid glitch.

## Timing
- Reset values: tx_valid=0, tx_data=0x00, sram_wr_en=0, sram_rd_en=0, sram_wr_addr=0, sram_rd_addr=0, sram_wr_data=0, busy=0, err_timeout=0, err_overrun=0; state IDLE; counter 0.
- All outputs are registered.
- Write: data byte at cycle t → sram_wr_en at t+1 → tx_valid at t+2.
- Read: addr byte at cycle t → sram_rd_en at t+1 → sram_rd_data sampled at t+2 → tx_valid at t+3.
- Unknown command at cycle t → tx_valid 0x3F at t+1.
- tx_valid and tx_data hold until tx_ready. With tx_ready tied high, tx_valid lasts exactly 1 cycle. The next byte is accepted the cycle after RESP exits.
- Throughput: one command in flight; the bridge does no pipelining.

## Test plan
- Write: rx 0x57,0xA5,0x3C with tx_ready=1 → exactly one cycle sram_wr_en=1, addr=0xA5, data=0x3C; then tx byte 0x4B; busy low afterwards.
- Read: preload SRAM model addr 0x10=0xC3; rx 0x52,0x10 → sram_rd_en at t+1, addr 0x10; tx byte 0xC3 at t+3. With tx_ready held low for 5 cycles, tx_valid/tx_data stay stable.
- Unknown/overrun: rx 0x41 → tx 0x3F, no SRAM strobe. Send a byte while in RESP with tx_ready=0 → err_overrun pulse, byte dropped, response unchanged.
- Timeout: TIMEOUT_CYCLES=16; rx 0x57,0x05, then silence → err_timeout after 16 cycles, no sram_wr_en, no tx. Repeat with a byte on the expiry cycle → accepted. With TIMEOUT_CYCLES=0 → no timeout ever.
- ADDR_WIDTH=4: rx 0x52,0xF7 → sram_rd_addr=0x7.
- Reset: assert rst_in during WDATA and during RESP → all outputs return to their reset values asynchronously; the next full write frame completes normally.

Source files
------------

// File: rtl/uart2sram_cmd_ctrl.sv
// uart2sram_cmd_ctrl
// Turns the UART receive byte stream into single SRAM write/read transactions
// and returns one response byte per command over a valid/ready handshake.
// Frames: 'W' addr data -> write, answered with 'K'
//         'R' addr      -> read, answered with the data byte
//         anything else -> '?'
// An inter-byte timeout abandons partial frames. Bytes that arrive while a
// command is executing or responding are dropped and flagged as overruns.
// Every output is driven straight from a flop.

module uart2sram_cmd_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_WIDTH  = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [7:0]            sram_wr_data,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [7:0]            sram_rd_data,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  err_overrun
);

  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ    = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_UNKNOWN = 8'h3F;  // '?'

  // A timeout of zero turns the inter-byte guard off entirely.
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST =
    TIMEOUT_WIDTH'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_WRITE,
    S_READ,
    S_RWAIT,
    S_RESP
  } state_t;

  // FSM state and latched frame fields
  state_t                   r_state;
  logic                     r_is_write;
  logic [ADDR_WIDTH-1:0]    r_wr_addr;
  logic [ADDR_WIDTH-1:0]    r_rd_addr;
  logic [7:0]               r_wr_data;
  logic [7:0]               r_tx_data;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;

  // Registered strobes and flags
  logic r_tx_valid;
  logic r_wr_en;
  logic r_rd_en;
  logic r_busy;
  logic r_err_timeout;
  logic r_err_overrun;

  // Next-state values
  state_t                   w_state_next;
  logic                     w_is_write_next;
  logic [ADDR_WIDTH-1:0]    w_wr_addr_next;
  logic [ADDR_WIDTH-1:0]    w_rd_addr_next;
  logic [7:0]               w_wr_data_next;
  logic [7:0]               w_tx_data_next;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_next;
  logic                     w_accept;
  logic                     w_timeout;
  logic                     w_overrun;
  logic                     w_expired;
  logic                     w_frame_next;

  // The partial frame has sat idle for the full allowance.
  assign w_expired = TIMEOUT_EN && (r_cnt == TIMEOUT_LAST);

  // State register; reset abandons any frame or pending response at once
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus next values of the latched fields and counter
  // NOTE: every variable gets a default at the top of the block so that no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_is_write_next = r_is_write;
    w_wr_addr_next  = r_wr_addr;
    w_rd_addr_next  = r_rd_addr;
    w_wr_data_next  = r_wr_data;
    w_tx_data_next  = r_tx_data;
    w_cnt_next      = '0;
    w_accept        = 1'b0;
    w_timeout       = 1'b0;
    w_overrun       = 1'b0;
    w_frame_next    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_accept = 1'b1;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            w_is_write_next = (rx_data == CMD_WRITE);
            w_state_next    = S_ADDR;
          end else begin
            w_tx_data_next = RSP_UNKNOWN;
            w_state_next   = S_RESP;
          end
        end
      end

      S_ADDR: begin
        // A byte on the expiry cycle takes priority over the timeout.
        if (rx_valid) begin
          w_accept = 1'b1;
          if (r_is_write) begin
            w_wr_addr_next = rx_data[ADDR_WIDTH-1:0];
            w_state_next   = S_WDATA;
          end else begin
            w_rd_addr_next = rx_data[ADDR_WIDTH-1:0];
            w_state_next   = S_READ;
          end
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_WDATA: begin
        if (rx_valid) begin
          w_accept       = 1'b1;
          w_wr_data_next = rx_data;
          w_state_next   = S_WRITE;
        end else if (w_expired) begin
          w_timeout    = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_WRITE: begin
        w_overrun      = rx_valid;
        w_tx_data_next = RSP_OK;
        w_state_next   = S_RESP;
      end

      S_READ: begin
        w_overrun    = rx_valid;
        w_state_next = S_RWAIT;
      end

      S_RWAIT: begin
        // The SRAM presents read data exactly one cycle after the strobe.
        w_overrun      = rx_valid;
        w_tx_data_next = sram_rd_data;
        w_state_next   = S_RESP;
      end

      S_RESP: begin
        w_overrun = rx_valid;
        if (tx_ready) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // The inter-byte counter runs only while waiting inside a frame and
    // restarts on every accepted byte.
    w_frame_next = (w_state_next == S_ADDR) || (w_state_next == S_WDATA);
    if (w_frame_next && !w_accept) begin
      w_cnt_next = TIMEOUT_EN ? r_cnt + TIMEOUT_WIDTH'(1) : r_cnt;
    end
  end

  // Latched frame fields, response byte and inter-byte counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_is_write <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_wr_data  <= '0;
      r_tx_data  <= '0;
      r_cnt      <= '0;
    end else begin
      r_is_write <= w_is_write_next;
      r_wr_addr  <= w_wr_addr_next;
      r_rd_addr  <= w_rd_addr_next;
      r_wr_data  <= w_wr_data_next;
      r_tx_data  <= w_tx_data_next;
      r_cnt      <= w_cnt_next;
    end
  end

  // Strobes and flags decoded from the next state so they line up with it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tx_valid    <= 1'b0;
      r_wr_en       <= 1'b0;
      r_rd_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_tx_valid    <= (w_state_next == S_RESP);
      r_wr_en       <= (w_state_next == S_WRITE);
      r_rd_en       <= (w_state_next == S_READ);
      r_busy        <= (w_state_next != S_IDLE);
      r_err_timeout <= w_timeout;
      r_err_overrun <= w_overrun;
    end
  end

  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign sram_wr_en   = r_wr_en;
  assign sram_wr_addr = r_wr_addr;
  assign sram_wr_data = r_wr_data;
  assign sram_rd_en   = r_rd_en;
  assign sram_rd_addr = r_rd_addr;
  assign busy         = r_busy;
  assign err_timeout  = r_err_timeout;
  assign err_overrun  = r_err_overrun;

endmodule

// File: tb/tb_uart2sram_cmd_ctrl.sv
// Directed bench for uart2sram_cmd_ctrl.
// dut0: ADDR_WIDTH=8, TIMEOUT_CYCLES=16. dut1: ADDR_WIDTH=4, timeout disabled.
// Both share the stimulus. Inputs change on the falling edge and outputs are
// sampled there too, so each rising edge consumes what was set half a cycle
// earlier.

module tb_uart2sram_cmd_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;

  always #5 clk_in = ~clk_in;

  // dut0 signals
  logic       tx_valid0, wr_en0, rd_en0, busy0, err_t0, err_o0;
  logic [7:0] tx_data0, wr_addr0, wr_data0, rd_addr0;
  logic [7:0] rd_data0 = 8'h00;

  // dut1 signals
  logic       tx_valid1, wr_en1, rd_en1, busy1, err_t1, err_o1;
  logic [7:0] tx_data1, wr_data1;
  logic [3:0] wr_addr1, rd_addr1;
  logic [7:0] rd_data1 = 8'h00;

  uart2sram_cmd_ctrl #(
    .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(32)
  ) dut0 (
    .clk_in(clk_in), .rst_in(rst_in),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready),
    .sram_wr_en(wr_en0), .sram_wr_addr(wr_addr0), .sram_wr_data(wr_data0),
    .sram_rd_en(rd_en0), .sram_rd_addr(rd_addr0), .sram_rd_data(rd_data0),
    .busy(busy0), .err_timeout(err_t0), .err_overrun(err_o0)
  );

  uart2sram_cmd_ctrl #(
    .ADDR_WIDTH(4), .TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(8)
  ) dut1 (
    .clk_in(clk_in), .rst_in(rst_in),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready),
    .sram_wr_en(wr_en1), .sram_wr_addr(wr_addr1), .sram_wr_data(wr_data1),
    .sram_rd_en(rd_en1), .sram_rd_addr(rd_addr1), .sram_rd_data(rd_data1),
    .busy(busy1), .err_timeout(err_t1), .err_overrun(err_o1)
  );

  // Read-only SRAM models: preloaded once, data returned one cycle after rd_en.
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [16];

  always @(posedge clk_in) begin
    if (rd_en0) rd_data0 <= mem0[rd_addr0];
    if (rd_en1) rd_data1 <= mem1[rd_addr1];
  end

  // Strobe and handshake counters for dut0
  int wr_cnt0 = 0;
  int rd_cnt0 = 0;
  int tx_cnt0 = 0;

  always @(posedge clk_in) begin
    if (wr_en0) wr_cnt0 <= wr_cnt0 + 1;
    if (rd_en0) rd_cnt0 <= rd_cnt0 + 1;
    if (tx_valid0 && tx_ready) tx_cnt0 <= tx_cnt0 + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // All dut0 outputs packed together; all-zero is the reset image.
  function automatic logic [63:0] outs0();
    return {26'd0, tx_valid0, tx_data0, wr_en0, wr_addr0, wr_data0,
            rd_en0, rd_addr0, busy0, err_t0, err_o0};
  endfunction

  // Present one byte for exactly one rising edge; call and return on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  // Safety net in case the DUT or bench stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_wr, base_rd, base_tx, waited;
    logic seen;

    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
    for (int i = 0; i < 16; i++)  mem1[i] = 8'h00;
    mem0[8'h10] = 8'hC3;
    mem1[4'h7]  = 8'h5A;

    rst_in   = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    check("reset_state", outs0(), 64'd0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // ---- Write frame W A5 3C ----
    base_tx = tx_cnt0;
    send_byte(8'h57);
    check("wr_busy_after_cmd", busy0, 1);
    send_byte(8'hA5);
    send_byte(8'h3C);
    check("wr_strobe", {wr_en0, wr_addr0, wr_data0}, {1'b1, 8'hA5, 8'h3C});
    @(negedge clk_in);
    check("wr_resp", {wr_en0, tx_valid0, tx_data0}, {1'b0, 1'b1, 8'h4B});
    @(negedge clk_in);
    check("wr_done", {tx_valid0, busy0}, 2'b00);
    check("wr_strobe_count", wr_cnt0, 1);
    check("wr_tx_count", tx_cnt0 - base_tx, 1);

    // ---- Read frame R 10 with tx_ready held low, then overrun in RESP ----
    tx_ready = 1'b0;
    send_byte(8'h52);
    send_byte(8'h10);
    check("rd_strobe", {rd_en0, rd_addr0}, {1'b1, 8'h10});
    @(negedge clk_in);
    check("rd_wait", {rd_en0, tx_valid0}, 2'b00);
    @(negedge clk_in);
    check("rd_resp", {tx_valid0, tx_data0}, {1'b1, 8'hC3});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      check("rd_resp_hold", {tx_valid0, tx_data0}, {1'b1, 8'hC3});
    end
    send_byte(8'h57);
    check("overrun_pulse", {err_o0, tx_valid0, tx_data0}, {1'b1, 1'b1, 8'hC3});
    @(negedge clk_in);
    check("overrun_clear", {err_o0, tx_valid0, tx_data0}, {1'b0, 1'b1, 8'hC3});
    tx_ready = 1'b1;
    @(negedge clk_in);
    check("rd_done_byte_dropped", {tx_valid0, busy0}, 2'b00);
    check("rd_strobe_count", rd_cnt0, 1);

    // ---- Unknown command ----
    base_wr = wr_cnt0;
    base_rd = rd_cnt0;
    send_byte(8'h41);
    check("unk_resp", {tx_valid0, tx_data0, busy0}, {1'b1, 8'h3F, 1'b1});
    @(negedge clk_in);
    check("unk_done", {tx_valid0, busy0}, 2'b00);
    check("unk_no_sram", (wr_cnt0 - base_wr) + (rd_cnt0 - base_rd), 0);

    // ---- Timeout in WDATA: 16 waiting cycles, then a pulse ----
    base_wr = wr_cnt0;
    base_tx = tx_cnt0;
    send_byte(8'h57);
    send_byte(8'h05);
    waited = 0;
    while (!err_t0 && waited < 40) begin
      @(negedge clk_in);
      waited++;
    end
    check("timeout_latency", waited, 16);
    check("timeout_idle", busy0, 0);
    @(negedge clk_in);
    check("timeout_pulse_len", err_t0, 0);
    check("timeout_no_side_effects", (wr_cnt0 - base_wr) + (tx_cnt0 - base_tx), 0);

    // ---- Byte on the expiry cycle wins ----
    send_byte(8'h57);
    send_byte(8'h05);
    repeat (15) @(negedge clk_in);
    send_byte(8'h99);
    check("expiry_byte_write", {err_t0, wr_en0, wr_addr0, wr_data0},
          {1'b0, 1'b1, 8'h05, 8'h99});
    @(negedge clk_in);
    check("expiry_byte_resp", {err_t0, tx_valid0, tx_data0}, {1'b0, 1'b1, 8'h4B});
    @(negedge clk_in);

    // ---- Asynchronous reset during WDATA ----
    send_byte(8'h57);
    send_byte(8'h11);
    check("rst_wdata_busy", busy0, 1);
    #2 rst_in = 1'b1;
    #1 check("rst_wdata_async", outs0(), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    // ---- Asynchronous reset during RESP ----
    tx_ready = 1'b0;
    send_byte(8'h57);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk_in);
    check("rst_resp_pending", {tx_valid0, tx_data0}, {1'b1, 8'h4B});
    #2 rst_in = 1'b1;
    #1 check("rst_resp_async", outs0(), 64'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_resp_stays_idle", outs0(), 64'd0);

    // ---- Full write frame after reset ----
    tx_ready = 1'b1;
    send_byte(8'h57);
    send_byte(8'h22);
    send_byte(8'h66);
    check("post_rst_wr", {wr_en0, wr_addr0, wr_data0}, {1'b1, 8'h22, 8'h66});
    @(negedge clk_in);
    check("post_rst_resp", {tx_valid0, tx_data0}, {1'b1, 8'h4B});
    @(negedge clk_in);

    // ---- dut1: clean start ----
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);

    // ADDR_WIDTH=4 keeps only the low nibble of the address byte.
    send_byte(8'h52);
    send_byte(8'hF7);
    check("aw4_rd_addr", {rd_en1, rd_addr1}, {1'b1, 4'h7});
    repeat (2) @(negedge clk_in);
    check("aw4_rd_resp", {tx_valid1, tx_data1}, {1'b1, 8'h5A});
    @(negedge clk_in);
    check("aw4_rd_done", {tx_valid1, busy1}, 2'b00);

    // Timeout disabled: a stalled frame waits indefinitely.
    send_byte(8'h57);
    send_byte(8'h03);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk_in);
      if (err_t1) seen = 1'b1;
    end
    check("no_timeout_flag", seen, 0);
    check("no_timeout_busy", busy1, 1);
    send_byte(8'h77);
    check("no_timeout_wr", {wr_en1, wr_addr1, wr_data1}, {1'b1, 4'h3, 8'h77});
    @(negedge clk_in);
    check("no_timeout_resp", {tx_valid1, tx_data1}, {1'b1, 8'h4B});
    @(negedge clk_in);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
